legv8_multicycle_sequencer: RTL and testbench
=============================================

Name: legv8_multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the LEGv8 datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, one instruction at a time.
- Drives the stage enables for instruction register load, decode/register read, ALU execute, data memory access, register-file write and PC update.
- Consumes the class signals from the main control decoder and the ALU zero flag.
- Adds req/ack handshakes to instruction and data memory, with a timeout watchdog and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: max request cycles without ack before entering ERR (legal range 2..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE and begin fetching.
- halt_req  input  1  stop at the next instruction boundary.
- mem_read  input  1  decoder MemRead.
- mem_write  input  1  decoder MemWrite.
- reg_write  input  1  decoder RegWrite.
- br_b  input  1  unconditional branch.
- br_bz  input  1  branch if zero (CBZ).
- br_bnz  input  1  branch if not zero (CBNZ).
- zero  input  1  ALU zero flag, valid during EXEC.
- imem_ack  input  1  instruction memory ack.
- dmem_ack  input  1  data memory ack.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  capture instruction word.
- id_en  output  1  decode / register read enable.
- ex_en  output  1  ALU enable.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write qualifier.
- rf_we  output  1  register-file write strobe.
- pc_inc  output  1  PC <= PC+4.
- pc_branch  output  1  PC <= branch target.
- busy  output  1  FSM active.
- err  output  1  sticky timeout error.
- state  output  3  current state code.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Code 7 is illegal and returns to IDLE on the next edge.
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, err=0, instr_count=0, wait_cnt=0;
  - latched control flags = 0;
  - all strobe outputs = 0.
  - Reset mid-instruction abandons the instruction; no PC or register-file strobe is produced.
- Output decoding: strobes are decoded combinationally from the current state, the latched flags and the current ack inputs. Each strobe lasts exactly one cycle unless stated otherwise.
- busy = (state is not IDLE and not ERR).
- IDLE: all strobes 0. If start=1 the next state is FETCH; otherwise stay in IDLE.
- FETCH:
  - imem_req=1, held every cycle until ack.
  - If imem_ack=1: ir_load=1 in the same cycle, next state DECODE.
- DECODE: id_en=1 for one cycle. On this edge the FSM latches mem_read, mem_write, reg_write, br_b, br_bz, br_bnz. Decoder changes after this edge are ignored until the next DECODE. Next state EXEC.
- EXEC: ex_en=1. The branch is taken if br_b, or br_bz&zero, or br_bnz&~zero (latched flags, live zero). Priority:
  1. Taken branch: pc_branch=1, instruction retires.
  2. mem_read or mem_write: next state MEM.
  3. reg_write: next state WB.
  4. Otherwise: pc_inc=1, instruction retires.
- MEM:
  - dmem_req=1 and dmem_we=mem_write, both held until ack.
  - On dmem_ack=1: if mem_read, next state WB; otherwise pc_inc=1 and the instruction retires.
  - If both mem_read and mem_write are latched, it is treated as a store followed by WB.
- WB: rf_we=1 and pc_inc=1, instruction retires.
- Retire:
  - instr_count increments by 1 and wraps modulo 2^CNT_W.
  - halt_req is sampled in the retire cycle: 1 gives next state IDLE, 0 gives FETCH.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU op = 4 cycles (F, D, E, W).
  - Load = 5 cycles.
  - Store = 4 cycles.
  - Branch or no-op = 3 cycles.
- Watchdog:
  - wait_cnt clears on entry to FETCH or MEM and increments each request cycle without ack.
  - An ack is accepted in any of the first TIMEOUT request cycles.
  - If the TIMEOUT-th request cycle has no ack, next state ERR.
  - An ack arriving in the same cycle as the TIMEOUT-th count wins; no error.
- ERR: err=1 and all strobes 0. ERR is left only by reset; start is ignored.
- Acks arriving outside FETCH/MEM are ignored.

Test Plan:
- ALU op (reg_write=1), imem_ack in the first FETCH cycle, start pulsed → state 1,2,3,5,1. ir_load, id_en, ex_en, rf_we+pc_inc each high 1 cycle; instr_count 0→1 on the WB edge.
- Load with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with rf_we=1; total 8 cycles. Store (mem_write=1, reg_write=0) → dmem_we=1, pc_inc in the ack cycle, no WB.
- CBZ with zero=1 → pc_branch=1 in EXEC, next FETCH. CBNZ with zero=1 → pc_inc=1, pc_branch=0.
- imem_ack never asserted, TIMEOUT=16 → imem_req high 16 cycles, then state=6, err=1, busy=0. A start pulse is then ignored; err clears only on rst_n=0.
- halt_req=1 during the WB cycle → next state IDLE, busy=0. Decoder inputs toggled during EXEC → latched flags unchanged.
- rst_n asserted low mid-MEM → state=0 immediately, dmem_req=0, instr_count=0; no rf_we ever asserted.

Source files
------------

// File: rtl/legv8_multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack
// memory handshakes, a request watchdog and a retired-instruction counter.
module legv8_multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             br_b,
  input  logic             br_bz,
  input  logic             br_bnz,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             id_en,
  output logic             ex_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StErr    = 3'd6
  } state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic br_b;
    logic br_bz;
    logic br_bnz;
  } flags_t;

  // Last request cycle index that may still accept an ack.
  localparam logic [7:0]       WaitLast = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;
  logic             br_taken;

  // State, latched decoder flags, watchdog and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      flags_q       <= '0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign br_taken = flags_q.br_b | (flags_q.br_bz & zero) | (flags_q.br_bnz & ~zero);

  // Next-state and strobe decode from current state, latched flags and live acks.
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    // Any state other than a waiting request cycle clears the watchdog, so
    // FETCH and MEM are always entered with a zero count.
    wait_cnt_d    = '0;
    instr_count_d = instr_count_q;
    retire        = 1'b0;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    id_en         = 1'b0;
    ex_en         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    pc_inc        = 1'b0;
    pc_branch     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StDecode: begin
        id_en   = 1'b1;
        flags_d = '{mem_read:  mem_read,  mem_write: mem_write, reg_write: reg_write,
                    br_b:      br_b,      br_bz:     br_bz,     br_bnz:    br_bnz};
        state_d = StExec;
      end
      StExec: begin
        ex_en = 1'b1;
        if (br_taken) begin
          pc_branch = 1'b1;
          retire    = 1'b1;
        end else if (flags_q.mem_read || flags_q.mem_write) begin
          state_d = StMem;
        end else if (flags_q.reg_write) begin
          state_d = StWb;
        end else begin
          pc_inc = 1'b1;
          retire = 1'b1;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = flags_q.mem_write;
        if (dmem_ack) begin
          if (flags_q.mem_read) begin
            state_d = StWb;
          end else begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StWb: begin
        rf_we  = 1'b1;
        pc_inc = 1'b1;
        retire = 1'b1;
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (retire) begin
      instr_count_d = instr_count_q + CntOne;
      state_d       = halt_req ? StIdle : StFetch;
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StErr);
  assign err         = (state_q == StErr);
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// Directed bench for the LEGv8 sequencer: stimulus pushes the expected
// per-cycle outputs into a queue, a negedge monitor pops and compares.
module tb_legv8_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req;
  logic        mem_read, mem_write, reg_write, br_b, br_bz, br_bnz, zero;
  logic        imem_ack, dmem_ack;
  logic        imem_req, ir_load, id_en, ex_en, dmem_req, dmem_we;
  logic        rf_we, pc_inc, pc_branch, busy, err;
  logic [2:0]  state;
  logic [31:0] instr_count;

  legv8_multicycle_sequencer #(
    .TIMEOUT(16),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .br_b       (br_b),
    .br_bz      (br_bz),
    .br_bnz     (br_bnz),
    .zero       (zero),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .id_en      (id_en),
    .ex_en      (ex_en),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .rf_we      (rf_we),
    .pc_inc     (pc_inc),
    .pc_branch  (pc_branch),
    .busy       (busy),
    .err        (err),
    .state      (state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Strobe vector bit positions:
  // {imem_req, ir_load, id_en, ex_en, dmem_req, dmem_we, rf_we, pc_inc, pc_branch, busy, err}
  localparam logic [10:0] IMREQ = 11'h400;
  localparam logic [10:0] IRLD  = 11'h200;
  localparam logic [10:0] IDEN  = 11'h100;
  localparam logic [10:0] EXEN  = 11'h080;
  localparam logic [10:0] DMREQ = 11'h040;
  localparam logic [10:0] DMWE  = 11'h020;
  localparam logic [10:0] RFWE  = 11'h010;
  localparam logic [10:0] PCINC = 11'h008;
  localparam logic [10:0] PCBR  = 11'h004;
  localparam logic [10:0] BUSYB = 11'h002;
  localparam logic [10:0] ERRB  = 11'h001;

  localparam logic [10:0] S_IDLE   = 11'h000;
  localparam logic [10:0] S_FREQ   = IMREQ | BUSYB;
  localparam logic [10:0] S_FACK   = IMREQ | IRLD | BUSYB;
  localparam logic [10:0] S_DEC    = IDEN | BUSYB;
  localparam logic [10:0] S_EX     = EXEN | BUSYB;
  localparam logic [10:0] S_EXINC  = EXEN | PCINC | BUSYB;
  localparam logic [10:0] S_EXBR   = EXEN | PCBR | BUSYB;
  localparam logic [10:0] S_MRD    = DMREQ | BUSYB;
  localparam logic [10:0] S_MWRINC = DMREQ | DMWE | PCINC | BUSYB;
  localparam logic [10:0] S_WB     = RFWE | PCINC | BUSYB;
  localparam logic [10:0] S_ERR    = ERRB;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [10:0] so;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {imem_req, ir_load, id_en, ex_en, dmem_req, dmem_we,
             rf_we, pc_inc, pc_branch, busy, err};
      checks++;
      if (state !== e.st || act !== e.so || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got state=%0d strobes=%b count=%0d, want state=%0d strobes=%b count=%0d",
                 e.name, state, act, instr_count, e.st, e.so, e.cnt);
      end
    end
  end

  // Record the expected outputs for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input logic [2:0] st, input logic [10:0] so,
                     input logic [31:0] cnt);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.so   = so;
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic mr, input logic mw, input logic rw,
                         input logic b, input logic bz, input logic bnz);
    mem_read  = mr;
    mem_write = mw;
    reg_write = rw;
    br_b      = b;
    br_bz     = bz;
    br_bnz    = bnz;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset", 3'd0, S_IDLE, 0);
    rst_n = 1'b1;
    cyc("idle", 3'd0, S_IDLE, 0);

    // ALU op, zero-wait fetch.
    set_dec(0, 0, 1, 0, 0, 0);
    start = 1'b1;
    cyc("alu_idle_start", 3'd0, S_IDLE, 0);
    start = 1'b0; imem_ack = 1'b1;
    cyc("alu_fetch", 3'd1, S_FACK, 0);
    imem_ack = 1'b0;
    cyc("alu_decode", 3'd2, S_DEC, 0);
    cyc("alu_exec", 3'd3, S_EX, 0);
    cyc("alu_wb", 3'd5, S_WB, 0);

    // Load with dmem ack on the fourth request cycle.
    set_dec(1, 0, 1, 0, 0, 0);
    imem_ack = 1'b1;
    cyc("ld_fetch", 3'd1, S_FACK, 1);
    imem_ack = 1'b0;
    cyc("ld_decode", 3'd2, S_DEC, 1);
    cyc("ld_exec", 3'd3, S_EX, 1);
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 3'd4, S_MRD, 1);
    dmem_ack = 1'b1;
    cyc("ld_mem_ack", 3'd4, S_MRD, 1);
    dmem_ack = 1'b0;
    cyc("ld_wb", 3'd5, S_WB, 1);

    // Store; decoder inputs toggled during EXEC must not disturb latched flags.
    set_dec(0, 1, 0, 0, 0, 0);
    imem_ack = 1'b1;
    cyc("st_fetch", 3'd1, S_FACK, 2);
    imem_ack = 1'b0;
    cyc("st_decode", 3'd2, S_DEC, 2);
    set_dec(1, 0, 1, 1, 1, 1);
    cyc("st_exec_toggle", 3'd3, S_EX, 2);
    set_dec(0, 0, 0, 0, 0, 0);
    dmem_ack = 1'b1;
    cyc("st_mem_ack", 3'd4, S_MWRINC, 2);
    dmem_ack = 1'b0;

    // CBZ with zero=1: taken.
    set_dec(0, 0, 0, 0, 1, 0);
    imem_ack = 1'b1;
    cyc("cbz_fetch", 3'd1, S_FACK, 3);
    imem_ack = 1'b0;
    cyc("cbz_decode", 3'd2, S_DEC, 3);
    zero = 1'b1;
    cyc("cbz_exec", 3'd3, S_EXBR, 3);

    // CBNZ with zero=1: not taken.
    set_dec(0, 0, 0, 0, 0, 1);
    imem_ack = 1'b1;
    cyc("cbnz_fetch", 3'd1, S_FACK, 4);
    imem_ack = 1'b0;
    cyc("cbnz_decode", 3'd2, S_DEC, 4);
    cyc("cbnz_exec", 3'd3, S_EXINC, 4);
    zero = 1'b0;

    // ALU op with halt_req in WB: back to IDLE.
    set_dec(0, 0, 1, 0, 0, 0);
    imem_ack = 1'b1;
    cyc("halt_fetch", 3'd1, S_FACK, 5);
    imem_ack = 1'b0;
    cyc("halt_decode", 3'd2, S_DEC, 5);
    cyc("halt_exec", 3'd3, S_EX, 5);
    halt_req = 1'b1;
    cyc("halt_wb", 3'd5, S_WB, 5);
    halt_req = 1'b0;

    // Fetch ack on the last permitted (16th) request cycle wins over timeout.
    set_dec(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc("wd_idle_start", 3'd0, S_IDLE, 6);
    start = 1'b0;
    for (int i = 0; i < 15; i++) cyc("wd_fetch_wait", 3'd1, S_FREQ, 6);
    imem_ack = 1'b1;
    cyc("wd_fetch_ack16", 3'd1, S_FACK, 6);
    imem_ack = 1'b0;
    cyc("wd_decode", 3'd2, S_DEC, 6);
    cyc("wd_exec_nop", 3'd3, S_EXINC, 6);

    // Reset asserted mid-MEM of a load.
    set_dec(1, 0, 1, 0, 0, 0);
    imem_ack = 1'b1;
    cyc("rst_fetch", 3'd1, S_FACK, 7);
    imem_ack = 1'b0;
    cyc("rst_decode", 3'd2, S_DEC, 7);
    cyc("rst_exec", 3'd3, S_EX, 7);
    cyc("rst_mem_wait", 3'd4, S_MRD, 7);
    rst_n = 1'b0;
    cyc("rst_mid_mem", 3'd0, S_IDLE, 0);
    rst_n = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0);
    cyc("rst_after", 3'd0, S_IDLE, 0);

    // Fetch never acked: ERR after 16 request cycles; start ignored in ERR.
    start = 1'b1;
    cyc("to_idle_start", 3'd0, S_IDLE, 0);
    start = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 3'd1, S_FREQ, 0);
    cyc("to_err", 3'd6, S_ERR, 0);
    start = 1'b1;
    cyc("to_err_start", 3'd6, S_ERR, 0);
    start = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    cyc("to_err_acks", 3'd6, S_ERR, 0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b0;
    cyc("to_err_reset", 3'd0, S_IDLE, 0);
    rst_n = 1'b1;
    cyc("to_idle_final", 3'd0, S_IDLE, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
